// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB register, load-response wait with timeout, load alignment and
// register-file write port. Optional macro WB_RVFI_EN adds retirement trace ports and checks.
module wb_stage #(
  parameter int unsigned LOAD_TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mem_valid,
  input  logic        mem_is_rd_write,
  input  logic [4:0]  mem_rd_addr,
  input  logic [31:0] mem_result,
  input  logic        mem_is_load,
  input  logic [2:0]  mem_load_funct3,
  input  logic [1:0]  mem_addr_lo,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_err,
  output logic        wb_stall,
  output logic        wb_q_is_rd_write,
  output logic [4:0]  wb_rd_addr,
  output logic [31:0] wb_rd_wdata,
  output logic        wb_load_fault,
  output logic [63:0] wb_instret
`ifdef WB_RVFI_EN
  ,
  output logic        rvfi_valid,
  output logic [4:0]  rvfi_rd_addr,
  output logic [31:0] rvfi_rd_wdata,
  output logic        rvfi_trap
`endif
);

  logic        valid_q;
  logic        rd_write_q;
  logic [4:0]  rd_q;
  logic [31:0] result_q;
  logic        is_load_q;
  logic [2:0]  funct3_q;
  logic [1:0]  addr_lo_q;
  logic [7:0]  wait_cnt_q;
  logic [63:0] instret_q;

  logic        in_hold;
  logic        in_wait;
  logic        timeout;
  logic        bad_access;
  logic        retire;
  logic        fault;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] load_data;

  assign in_hold = valid_q && !is_load_q;
  assign in_wait = valid_q && is_load_q;
  assign timeout = in_wait && (wait_cnt_q == 8'(LOAD_TIMEOUT));

  always_comb begin
    bad_access = 1'b0;
    unique case (funct3_q)
      3'b000, 3'b100: bad_access = 1'b0;
      3'b001, 3'b101: bad_access = addr_lo_q[0];
      3'b010:         bad_access = (addr_lo_q != 2'b00);
      default:        bad_access = 1'b1;
    endcase
  end

  assign byte_v = dmem_rdata[{addr_lo_q, 3'b000} +: 8];
  assign half_v = dmem_rdata[{addr_lo_q[1], 4'b0000} +: 16];

  always_comb begin
    load_data = dmem_rdata;
    unique case (funct3_q)
      3'b000:  load_data = {{24{byte_v[7]}}, byte_v};
      3'b100:  load_data = {24'h0, byte_v};
      3'b001:  load_data = {{16{half_v[15]}}, half_v};
      3'b101:  load_data = {16'h0, half_v};
      default: load_data = dmem_rdata;
    endcase
  end

  // A response in the same cycle as the timeout wins and completes normally.
  always_comb begin
    wb_stall         = 1'b0;
    retire           = 1'b0;
    fault            = 1'b0;
    wb_q_is_rd_write = 1'b0;
    wb_rd_addr       = 5'd0;
    wb_rd_wdata      = 32'd0;
    if (!rst_i) begin
      wb_stall         = in_wait && !dmem_rvalid && !timeout;
      retire           = in_hold || (in_wait && (dmem_rvalid || timeout));
      fault            = in_wait && (dmem_rvalid ? (dmem_err || bad_access) : timeout);
      wb_q_is_rd_write = retire && rd_write_q && (rd_q != 5'd0) && !fault;
      wb_rd_addr       = rd_q;
      wb_rd_wdata      = is_load_q ? load_data : result_q;
    end
  end

  assign wb_load_fault = fault;
  assign wb_instret    = instret_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q    <= 1'b0;
      rd_write_q <= 1'b0;
      rd_q       <= 5'd0;
      result_q   <= 32'd0;
      is_load_q  <= 1'b0;
      funct3_q   <= 3'd0;
      addr_lo_q  <= 2'd0;
      wait_cnt_q <= 8'd0;
      instret_q  <= 64'd0;
    end else begin
      if (!wb_stall) begin
        valid_q    <= mem_valid;
        rd_write_q <= mem_is_rd_write;
        rd_q       <= mem_rd_addr;
        result_q   <= mem_result;
        is_load_q  <= mem_is_load;
        funct3_q   <= mem_load_funct3;
        addr_lo_q  <= mem_addr_lo;
        wait_cnt_q <= 8'd0;
      end else begin
        wait_cnt_q <= wait_cnt_q + 8'd1;
      end
      if (retire) begin
        instret_q <= instret_q + 64'd1;
      end
    end
  end

`ifdef WB_RVFI_EN
  assign rvfi_valid    = retire;
  assign rvfi_rd_addr  = wb_q_is_rd_write ? wb_rd_addr : 5'd0;
  assign rvfi_rd_wdata = wb_q_is_rd_write ? wb_rd_wdata : 32'd0;
  assign rvfi_trap     = wb_load_fault;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(wb_q_is_rd_write && (wb_rd_addr == 5'd0)));
      assert (!wb_stall || in_wait);
    end
  end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed cases then random instruction stream,
// checked each cycle against an instruction-level reference model.
module tb_wb_stage;

  localparam int TO = 4;

  typedef struct {
    bit          v;
    bit          rdw;
    logic [4:0]  rd;
    logic [31:0] res;
    bit          ld;
    logic [2:0]  f3;
    logic [1:0]  alo;
    int          delay;
    logic [31:0] rdata;
    bit          err;
  } ins_t;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        mem_valid, mem_is_rd_write, mem_is_load;
  logic [4:0]  mem_rd_addr;
  logic [31:0] mem_result;
  logic [2:0]  mem_load_funct3;
  logic [1:0]  mem_addr_lo;
  logic        dmem_rvalid, dmem_err;
  logic [31:0] dmem_rdata;
  logic        wb_stall, wb_q_is_rd_write, wb_load_fault;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_rd_wdata;
  logic [63:0] wb_instret;
`ifdef WB_RVFI_EN
  logic        rvfi_valid, rvfi_trap;
  logic [4:0]  rvfi_rd_addr;
  logic [31:0] rvfi_rd_wdata;
`endif

  wb_stage #(.LOAD_TIMEOUT(TO)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .mem_valid        (mem_valid),
    .mem_is_rd_write  (mem_is_rd_write),
    .mem_rd_addr      (mem_rd_addr),
    .mem_result       (mem_result),
    .mem_is_load      (mem_is_load),
    .mem_load_funct3  (mem_load_funct3),
    .mem_addr_lo      (mem_addr_lo),
    .dmem_rvalid      (dmem_rvalid),
    .dmem_rdata       (dmem_rdata),
    .dmem_err         (dmem_err),
    .wb_stall         (wb_stall),
    .wb_q_is_rd_write (wb_q_is_rd_write),
    .wb_rd_addr       (wb_rd_addr),
    .wb_rd_wdata      (wb_rd_wdata),
    .wb_load_fault    (wb_load_fault),
    .wb_instret       (wb_instret)
`ifdef WB_RVFI_EN
    ,
    .rvfi_valid       (rvfi_valid),
    .rvfi_rd_addr     (rvfi_rd_addr),
    .rvfi_rd_wdata    (rvfi_rd_wdata),
    .rvfi_trap        (rvfi_trap)
`endif
  );

  always #5 clk_i = ~clk_i;

  int          total = 0;
  int          bad = 0;
  ins_t        q[$];
  ins_t        cur;
  bit          have = 0;
  int          k = 0;
  logic [63:0] iexp = 64'd0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [1:0] alo,
                                           input logic [31:0] d);
    longint dl, b, h;
    int     a;
    a  = int'(alo);
    dl = longint'(d);
    b  = (dl / (longint'(1) << (8 * a))) % 256;
    h  = (dl / (longint'(1) << (16 * (a / 2)))) % 65536;
    case (f3)
      3'd0:    return (b >= 128) ? 32'(b - 256) : 32'(b);
      3'd4:    return 32'(b);
      3'd1:    return (h >= 32768) ? 32'(h - 65536) : 32'(h);
      3'd5:    return 32'(h);
      default: return d;
    endcase
  endfunction

  function automatic bit load_bad(input logic [2:0] f3, input logic [1:0] alo);
    int a;
    a = int'(alo);
    if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
    if ((f3 == 3'd1 || f3 == 3'd5) && (a % 2 != 0)) return 1'b1;
    if (f3 == 3'd2 && a != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic ins_t mk(input bit v, input bit rdw, input int rd, input logic [31:0] res,
                              input bit ld, input int f3, input int alo, input int delay,
                              input logic [31:0] rdata, input bit err);
    ins_t t;
    t.v = v; t.rdw = rdw; t.rd = 5'(rd); t.res = res; t.ld = ld; t.f3 = 3'(f3);
    t.alo = 2'(alo); t.delay = delay; t.rdata = rdata; t.err = err;
    return t;
  endfunction

  function automatic ins_t rnd_ins();
    ins_t t;
    t.v     = ($urandom_range(0, 4) != 0);
    t.rdw   = $urandom_range(0, 1) == 1;
    t.rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    t.res   = $urandom;
    t.ld    = $urandom_range(0, 1) == 1;
    t.f3    = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7))
                                          : 3'($urandom_range(0, 2));
    if (t.f3 == 3'd2 && $urandom_range(0, 1) == 1) t.f3 = 3'd4;
    if (t.f3 == 3'd1 && $urandom_range(0, 1) == 1) t.f3 = 3'd5;
    t.alo   = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'd0;
    if (t.f3 inside {3'd0, 3'd4}) t.alo = 2'($urandom_range(0, 3));
    t.delay = $urandom_range(0, 6);
    t.rdata = $urandom;
    t.err   = ($urandom_range(0, 9) == 0);
    return t;
  endfunction

  task automatic drive_mem(input ins_t t);
    mem_valid       = t.v;
    mem_is_rd_write = t.rdw;
    mem_rd_addr     = t.rd;
    mem_result      = t.res;
    mem_is_load     = t.ld;
    mem_load_funct3 = t.f3;
    mem_addr_lo     = t.alo;
  endtask

  // One clock cycle of stimulus plus checks against the instruction-level model.
  task automatic step();
    ins_t        nx;
    bit          ret, flt, we_e, stall_e;
    logic [31:0] wd;
    int          ret_k;
    @(negedge clk_i);
    ret = 0; flt = 0; we_e = 0; stall_e = 0; wd = 32'd0;
    dmem_rvalid = ($urandom_range(0, 3) == 0);
    dmem_rdata  = $urandom;
    dmem_err    = $urandom_range(0, 1) == 1;
    if (have) begin
      if (!cur.ld) begin
        ret = (k == 0);
      end else begin
        ret_k       = (cur.delay < TO) ? cur.delay : TO;
        ret         = (k == ret_k);
        dmem_rvalid = (k == cur.delay);
        dmem_rdata  = cur.rdata;
        dmem_err    = cur.err;
      end
      flt     = cur.ld && ret && (cur.delay > TO || cur.err || load_bad(cur.f3, cur.alo));
      we_e    = ret && cur.rdw && (cur.rd != 5'd0) && !flt;
      stall_e = cur.ld && !ret;
      wd      = cur.ld ? load_val(cur.f3, cur.alo, cur.rdata) : cur.res;
    end
    if (!have || ret) begin
      if (q.size() > 0) nx = q.pop_front();
      else nx = mk(0, 0, 0, 32'd0, 0, 0, 0, 0, 32'd0, 0);
    end else begin
      nx = rnd_ins();
      nx.v = 1'b1;
    end
    drive_mem(nx);
    #1;
    chk("stall", 64'(wb_stall), 64'(stall_e));
    chk("we", 64'(wb_q_is_rd_write), 64'(we_e));
    chk("fault", 64'(wb_load_fault), 64'(flt));
    chk("instret", wb_instret, iexp);
    if (have) chk("addr", 64'(wb_rd_addr), 64'(cur.rd));
    if (we_e) chk("wdata", 64'(wb_rd_wdata), 64'(wd));
    @(posedge clk_i);
    if (ret) iexp++;
    if (!have || ret) begin
      have = nx.v;
      cur  = nx;
      k    = 0;
    end else begin
      k++;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_stall"}, 64'(wb_stall), 64'd0);
    chk({tag, "_we"}, 64'(wb_q_is_rd_write), 64'd0);
    chk({tag, "_fault"}, 64'(wb_load_fault), 64'd0);
    chk({tag, "_addr"}, 64'(wb_rd_addr), 64'd0);
    chk({tag, "_wdata"}, 64'(wb_rd_wdata), 64'd0);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((q.size() > 0 || have) && guard < 5000) begin
      step();
      guard++;
    end
    chk("drain_done", 64'(q.size() + int'(have)), 64'd0);
  endtask

  initial begin
    rst_i = 1'b1;
    drive_mem(mk(0, 0, 0, 32'd0, 0, 0, 0, 0, 32'd0, 0));
    dmem_rvalid = 1'b0; dmem_rdata = 32'd0; dmem_err = 1'b0;
    repeat (2) @(negedge clk_i);
    #1;
    chk_reset_outputs("init_rst");
    chk("init_instret", wb_instret, 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Directed cases
    q.push_back(mk(1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 32'd0, 0));
    q.push_back(mk(1, 1, 7, 32'd0, 1, 0, 3, 2, 32'h80112233, 0));   // LB
    q.push_back(mk(1, 1, 7, 32'd0, 1, 4, 3, 2, 32'h80112233, 0));   // LBU
    q.push_back(mk(1, 1, 9, 32'd0, 1, 5, 2, 0, 32'hBEEF1234, 0));   // LHU
    q.push_back(mk(1, 1, 9, 32'd0, 1, 1, 1, 1, 32'hBEEF1234, 0));   // LH misaligned
    q.push_back(mk(1, 1, 3, 32'd0, 1, 2, 0, 99, 32'h0, 0));         // timeout
    q.push_back(mk(0, 0, 0, 32'd0, 0, 0, 0, 0, 32'd0, 0));
    q.push_back(mk(1, 1, 0, 32'h12345678, 0, 0, 0, 0, 32'd0, 0));   // rd=0
    q.push_back(mk(1, 1, 4, 32'd0, 1, 2, 0, 1, 32'hCAFEF00D, 1));   // bus error
    q.push_back(mk(1, 1, 6, 32'd0, 1, 2, 0, TO, 32'h01234567, 0));  // rvalid at timeout
    q.push_back(mk(1, 1, 8, 32'd0, 1, 3, 0, 0, 32'h55AA55AA, 0));   // illegal funct3
    q.push_back(mk(1, 1, 10, 32'hA5A5A5A5, 0, 0, 0, 0, 32'd0, 0));
    drain();

    // Reset while a load is waiting
    q.push_back(mk(1, 1, 12, 32'd0, 1, 2, 0, 50, 32'h0, 0));
    repeat (3) step();
    @(negedge clk_i);
    rst_i = 1'b1;
    dmem_rvalid = 1'b0;
    drive_mem(mk(0, 0, 0, 32'd0, 0, 0, 0, 0, 32'd0, 0));
    #1;
    chk_reset_outputs("rst_wait");
    @(negedge clk_i);
    #1;
    chk_reset_outputs("rst_after");
    chk("rst_instret", wb_instret, 64'd0);
    have = 0;
    iexp = 64'd0;
    @(negedge clk_i);
    rst_i = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata = 32'hFFFFFFFF;
    #1;
    chk("stray_we", 64'(wb_q_is_rd_write), 64'd0);
    chk("stray_fault", 64'(wb_load_fault), 64'd0);
    chk("stray_stall", 64'(wb_stall), 64'd0);
    @(posedge clk_i);
    #1;
    chk("stray_instret", wb_instret, 64'd0);

    // Random stream
    for (int i = 0; i < 300; i++) q.push_back(rnd_ins());
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
